// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_pkg
// Brief    : Shared state encoding and LED colour constants for the code lock.
// Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    typedef enum logic [2:0] {
        ENROLL   = 3'd0,
        VERIFY   = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        FAIL     = 3'd4,
        LOCKOUT  = 3'd5
    } state_t;

    // Active-low RGB: [2]=red, [1]=blue, [0]=green
    localparam logic [2:0] LED_OFF   = 3'b111;
    localparam logic [2:0] LED_RED   = 3'b011;
    localparam logic [2:0] LED_BLUE  = 3'b101;
    localparam logic [2:0] LED_GREEN = 3'b110;

endpackage : code_lock_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Two-flop synchroniser plus stable-sample counter for a raw button.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btnRaw,
    output logic o_btnLevel
);

    localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    // Level flips only after DEB_CYCLES consecutive samples that disagree with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btnRaw;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btnLevel = r_level;

endmodule : button_debounce
`default_nettype wire

// File: rtl/code_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_param
// Brief    : Two-button code lock with enrol/verify, attempt limit and lockout.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_param
    import code_lock_pkg::*;
#(
    parameter int CODE_LEN   = 6,
    parameter int DEB_CYCLES = 500000,
    parameter int BLINK_HALF = 10000000,
    parameter int MAX_TRIES  = 3,
    parameter int FAIL_HOLD  = 50000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           butonA,
    input  logic                           butonB,
    output logic [2:0]                     led,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

    localparam int c_IDX_W   = $clog2(CODE_LEN);
    localparam int c_FC_W    = $clog2(MAX_TRIES + 1);
    localparam int c_TMR_MAX = (BLINK_HALF > FAIL_HOLD) ? BLINK_HALF : FAIL_HOLD;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(CODE_LEN - 1);
    localparam logic [c_FC_W-1:0]  c_FC_MAX     = c_FC_W'(MAX_TRIES);
    localparam logic [c_TMR_W-1:0] c_BLINK_LAST = c_TMR_W'(BLINK_HALF - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST  = c_TMR_W'(FAIL_HOLD - 1);

    logic w_levelA;
    logic w_levelB;
    logic r_armed;
    logic w_pressA;
    logic w_pressB;
    logic w_press;

    state_t              r_state,     w_stateNext;
    logic [c_IDX_W-1:0]  r_bitIdx,    w_bitIdxNext;
    logic [CODE_LEN-1:0] r_code,      w_codeNext;
    logic [CODE_LEN-1:0] r_attempt,   w_attemptNext;
    logic [c_FC_W-1:0]   r_failCnt,   w_failCntNext;
    logic [c_FC_W-1:0]   w_failInc;
    logic [c_TMR_W-1:0]  r_timer,     w_timerNext;
    logic                r_blinkOn,   w_blinkOnNext;
    logic                r_first;
    logic                w_entry;
    logic [2:0]          r_led,       w_ledNext;
    logic                r_unlocked,  w_unlockedNext;
    logic                r_lockedOut, w_lockedOutNext;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debA (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btnRaw   (butonA),
        .o_btnLevel (w_levelA)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debB (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btnRaw   (butonB),
        .o_btnLevel (w_levelB)
    );

    assign w_pressA  = r_armed & ~w_levelA &  w_levelB;
    assign w_pressB  = r_armed &  w_levelA & ~w_levelB;
    assign w_press   = w_pressA | w_pressB;
    assign w_failInc = r_failCnt + 1'b1;

    // A chord (both low) disarms too, so releasing one button of it cannot fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b1;
        end else if (w_press || (!w_levelA && !w_levelB)) begin
            r_armed <= 1'b0;
        end else if (w_levelA && w_levelB) begin
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_bitIdxNext  = r_bitIdx;
        w_codeNext    = r_code;
        w_attemptNext = r_attempt;
        w_failCntNext = r_failCnt;

        case (r_state)
            ENROLL: begin
                if (w_press) begin
                    w_codeNext[r_bitIdx] = w_pressB;
                    if (r_bitIdx == c_IDX_LAST) begin
                        w_bitIdxNext = '0;
                        w_stateNext  = VERIFY;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (w_press) begin
                    w_attemptNext[r_bitIdx] = w_pressB;
                    if (r_bitIdx == c_IDX_LAST) begin
                        w_bitIdxNext = '0;
                        w_stateNext  = CHECK;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 1'b1;
                    end
                end
            end
            CHECK: begin
                w_attemptNext = '0;
                if (r_attempt == r_code) begin
                    w_stateNext   = UNLOCKED;
                    w_failCntNext = '0;
                end else begin
                    w_failCntNext = w_failInc;
                    w_stateNext   = (w_failInc == c_FC_MAX) ? LOCKOUT : FAIL;
                end
            end
            UNLOCKED: begin
                if (w_pressA) begin
                    w_stateNext   = VERIFY;
                    w_attemptNext = '0;
                    w_bitIdxNext  = '0;
                end else if (w_pressB) begin
                    w_stateNext   = ENROLL;
                    w_codeNext    = '0;
                    w_failCntNext = '0;
                    w_bitIdxNext  = '0;
                end
            end
            FAIL: begin
                w_attemptNext = '0;
                w_bitIdxNext  = '0;
                if (r_timer == c_HOLD_LAST) begin
                    w_stateNext = VERIFY;
                end
            end
            LOCKOUT: begin
                w_stateNext = LOCKOUT;
            end
            default: begin
                w_stateNext = ENROLL;
            end
        endcase

        // The first cycle out of reset counts as an entry so blinking starts colour-on
        w_entry = r_first || (w_stateNext != r_state);
        if (w_entry) begin
            w_timerNext   = '0;
            w_blinkOnNext = 1'b1;
        end else if (r_state != FAIL && r_timer == c_BLINK_LAST) begin
            w_timerNext   = '0;
            w_blinkOnNext = ~r_blinkOn;
        end else begin
            w_timerNext   = r_timer + 1'b1;
            w_blinkOnNext = r_blinkOn;
        end

        w_ledNext = r_led;
        case (w_stateNext)
            ENROLL:   w_ledNext = w_blinkOnNext ? LED_BLUE  : LED_OFF;
            VERIFY:   w_ledNext = w_blinkOnNext ? LED_GREEN : LED_OFF;
            UNLOCKED: w_ledNext = LED_GREEN;
            FAIL:     w_ledNext = LED_RED;
            LOCKOUT:  w_ledNext = LED_RED;
            default:  w_ledNext = r_led;
        endcase
        w_unlockedNext  = (w_stateNext == UNLOCKED);
        w_lockedOutNext = (w_stateNext == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ENROLL;
            r_bitIdx    <= '0;
            r_code      <= '0;
            r_attempt   <= '0;
            r_failCnt   <= '0;
            r_timer     <= '0;
            r_blinkOn   <= 1'b1;
            r_first     <= 1'b1;
            r_led       <= LED_OFF;
            r_unlocked  <= 1'b0;
            r_lockedOut <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_bitIdx    <= w_bitIdxNext;
            r_code      <= w_codeNext;
            r_attempt   <= w_attemptNext;
            r_failCnt   <= w_failCntNext;
            r_timer     <= w_timerNext;
            r_blinkOn   <= w_blinkOnNext;
            r_first     <= 1'b0;
            r_led       <= w_ledNext;
            r_unlocked  <= w_unlockedNext;
            r_lockedOut <= w_lockedOutNext;
        end
    end

    assign led        = r_led;
    assign unlocked   = r_unlocked;
    assign locked_out = r_lockedOut;
    assign fail_cnt   = r_failCnt;

endmodule : code_lock_param
`default_nettype wire

// File: doc/code_lock_param.md
Name: code_lock_param

Overview:
- Parametrised two-button code lock: enrol a CODE_LEN-bit code, then verify entered attempts against it.
- Adds over the previous lock: debounce, attempt limit with lockout, timed fail display, relock and re-enrol from the unlocked state.
- Drives the board's active-low RGB LED.
- Top-level user-interface block; buttons come straight from pins.

Parameters:
CODE_LEN, 6, code length in bits (2..16)
DEB_CYCLES, 500000, clock cycles a raw button level must be stable before acceptance
BLINK_HALF, 10000000, cycles per blink half-period in ENROLL/VERIFY
MAX_TRIES, 3, consecutive wrong attempts that trigger LOCKOUT (1..15)
FAIL_HOLD, 50000000, cycles solid red is shown after a wrong attempt

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
butonA  in  1  raw button, low = pressed, enters bit 0
butonB  in  1  raw button, low = pressed, enters bit 1
led  out  3  active-low RGB: [2]=red, [1]=blue, [0]=green; 111 = off
unlocked  out  1  high while in UNLOCKED
locked_out  out  1  high while in LOCKOUT
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive wrong attempts

Behaviour:
- Reset (async assert, sync release):
  - State ENROLL; led=111; unlocked=0; locked_out=0; fail_cnt=0.
  - bit_idx=0; code and attempt registers 0; debounced levels=1 (released); armed=1.
- Input path: each button uses a 2-flop synchroniser, then a debouncer. The debounced level changes only after DEB_CYCLES consecutive equal synchronised samples.
- Press pulse (1 cycle):
  - Issued when armed=1 and exactly one debounced level is 0. armed then clears.
  - armed sets only when both debounced levels are 1.
  - Both buttons low together: no pulse; stays unarmed until both are released.
- Bit storage: LSB-first; the k-th accepted press writes bit k-1. A press pulse writes bit_idx and increments it.
- ENROLL:
  - LED blinks blue: 101 for BLINK_HALF cycles, then 111 for BLINK_HALF, repeating. The phase counter restarts at 0 with colour-on at every state entry.
  - The press writing bit CODE_LEN-1 goes to VERIFY; bit_idx returns to 0.
- VERIFY:
  - LED blinks green (110/111), same timing.
  - The press writing bit CODE_LEN-1 goes to CHECK. The full attempt, including the last bit, is registered in that cycle.
- CHECK (exactly 1 cycle):
  - attempt==code: go to UNLOCKED, fail_cnt=0.
  - Otherwise fail_cnt+1. If the new value equals MAX_TRIES, go to LOCKOUT; else go to FAIL.
  - Outcome state is visible 2 cycles after the last press pulse.
- UNLOCKED:
  - led=110 solid; unlocked=1.
  - butonA press: relock to VERIFY (attempt cleared).
  - butonB press: go to ENROLL; code cleared; fail_cnt=0.
- FAIL:
  - led=011 solid for exactly FAIL_HOLD cycles, then VERIFY. Attempt and bit_idx cleared.
  - Presses are ignored and not buffered.
- LOCKOUT: led=011 solid; locked_out=1; all presses ignored; exit only by rst_n.
- Press pulses in CHECK are dropped.
- bit_idx never exceeds CODE_LEN-1; no wrap beyond the code.
- Reset mid-entry discards all partial state, including the enrolled code.
- All outputs are registered.

Decomposition:
- Package code_lock_pkg holds:
  - state enum: ENROLL, VERIFY, CHECK, UNLOCKED, FAIL, LOCKOUT
  - LED constants: LED_OFF=111, LED_RED=011, LED_BLUE=101, LED_GREEN=110
- Sub-module button_debounce (parameter DEB_CYCLES): synchroniser plus stable counter. Two instances, one per button.
- The FSM, blink/hold timer and code registers stay in code_lock_param.

Test Plan (CODE_LEN=4, DEB_CYCLES=4, BLINK_HALF=8, MAX_TRIES=2, FAIL_HOLD=16):
1. Reset, idle 40 cycles -> led alternates 101/111 every 8 cycles starting 101; fail_cnt=0.
2. Enrol A,B,B,A (code=4'b0110), verify A,B,B,A -> CHECK then UNLOCKED 2 cycles after last pulse; led=110; unlocked=1; fail_cnt=0.
3. Bench glitches:
   - 2-cycle low glitch on butonA -> no bit written.
   - Both buttons held low 20 cycles -> no bit written; a following single press is accepted only after both are released.
4. Code 0110, wrong attempt 1111 -> led=011 for exactly 16 cycles, fail_cnt=1, then green blink; presses during FAIL ignored (bit_idx stays 0).
5. Two consecutive wrong attempts -> LOCKOUT, locked_out=1, led=011 held 1000 cycles despite presses; rst_n low -> ENROLL, led=111.
6. In UNLOCKED, press butonB -> ENROLL with code cleared; re-enrol 1001 and verify 1001 -> UNLOCKED; assert rst_n after 2 bits of an attempt -> all registers at reset values.
